// File: rtl/bcd_pair_counter.sv
// Two-digit BCD time-field counter with preset, runtime top and range check.
// Define BCD_COUNTER_DOWN_EN to add the dec input and borrow_out pulse.
module bcd_pair_counter #(
  parameter int MOD_VAL = 60,
  parameter int MIN_VAL = 0,
  parameter int DYN_TOP = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_bcd,
  input  logic [7:0] top_bcd,
`ifdef BCD_COUNTER_DOWN_EN
  input  logic       dec,
`endif
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       carry_out,
`ifdef BCD_COUNTER_DOWN_EN
  output logic       borrow_out,
`endif
  output logic       load_err
);

  localparam int TOPV = MOD_VAL - 1;
  localparam logic [7:0] MIN_BCD = 8'(MIN_VAL);
  localparam logic [7:0] STATIC_TOP =
    {4'(TOPV / 10), 4'(TOPV % 10)};

  logic [7:0] val_q, val_d;
  logic       carry_q, carry_d;
  logic       err_q, err_d;
  logic [7:0] top;
  logic       top_ok;
  logic       load_ok;
  logic       up;

  // A malformed runtime top collapses the range to MIN.
  assign top_ok = (top_bcd[7:4] <= 4'd9)
                & (top_bcd[3:0] <= 4'd9)
                & (top_bcd >= MIN_BCD);

  assign top = (DYN_TOP != 0)
             ? (top_ok ? top_bcd : MIN_BCD)
             : STATIC_TOP;

  assign load_ok = (load_bcd[7:4] <= 4'd9)
                 & (load_bcd[3:0] <= 4'd9)
                 & (load_bcd >= MIN_BCD)
                 & (load_bcd <= top);

`ifdef BCD_COUNTER_DOWN_EN
  logic borrow_q, borrow_d;
  logic dn;

  assign up = ~load & inc & ~dec;
  assign dn = ~load & dec & ~inc;
`else
  assign up = ~load & inc;
`endif

  always_comb begin
    val_d   = val_q;
    carry_d = 1'b0;
    err_d   = 1'b0;
`ifdef BCD_COUNTER_DOWN_EN
    borrow_d = 1'b0;
`endif
    unique case (1'b1)
      load: begin
        if (load_ok) begin
          val_d = load_bcd;
        end else begin
          err_d = 1'b1;
        end
      end
      up: begin
        if (val_q >= top) begin
          val_d   = MIN_BCD;
          carry_d = 1'b1;
        end else if (val_q[3:0] == 4'd9) begin
          val_d = {val_q[7:4] + 4'd1, 4'd0};
        end else begin
          val_d = {val_q[7:4], val_q[3:0] + 4'd1};
        end
      end
`ifdef BCD_COUNTER_DOWN_EN
      dn: begin
        if (val_q <= MIN_BCD) begin
          val_d    = top;
          borrow_d = 1'b1;
        end else if (val_q[3:0] == 4'd0) begin
          val_d = {val_q[7:4] - 4'd1, 4'd9};
        end else begin
          val_d = {val_q[7:4], val_q[3:0] - 4'd1};
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val_q   <= MIN_BCD;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      val_q   <= val_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

`ifdef BCD_COUNTER_DOWN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      borrow_q <= 1'b0;
    end else begin
      borrow_q <= borrow_d;
    end
  end

  assign borrow_out = borrow_q;
`endif

  assign tens      = val_q[7:4];
  assign ones      = val_q[3:0];
  assign carry_out = carry_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_bcd_pair_counter.sv
// Bench for bcd_pair_counter: three parameterisations vs. an integer model.
// Define BCD_COUNTER_DOWN_EN to also exercise the down-count path.
module tb_bcd_pair_counter;

`ifdef BCD_COUNTER_DOWN_EN
  localparam bit DOWN = 1'b1;
`else
  localparam bit DOWN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [2:0]      inc, dec, load;
  logic [2:0][7:0] lbcd;
  logic [7:0]      top_c;
  logic [2:0][3:0] tens, ones;
  logic [2:0]      carry, borrow, lerr;

`ifndef BCD_COUNTER_DOWN_EN
  assign borrow = 3'b000;
`endif

  bcd_pair_counter #(.MOD_VAL(60), .MIN_VAL(0), .DYN_TOP(0)) u_a (
    .clk(clk), .rst_n(rst_n), .inc(inc[0]), .load(load[0]),
    .load_bcd(lbcd[0]), .top_bcd(8'h00),
`ifdef BCD_COUNTER_DOWN_EN
    .dec(dec[0]),
`endif
    .tens(tens[0]), .ones(ones[0]), .carry_out(carry[0]),
`ifdef BCD_COUNTER_DOWN_EN
    .borrow_out(borrow[0]),
`endif
    .load_err(lerr[0]));

  bcd_pair_counter #(.MOD_VAL(13), .MIN_VAL(1), .DYN_TOP(0)) u_b (
    .clk(clk), .rst_n(rst_n), .inc(inc[1]), .load(load[1]),
    .load_bcd(lbcd[1]), .top_bcd(8'h00),
`ifdef BCD_COUNTER_DOWN_EN
    .dec(dec[1]),
`endif
    .tens(tens[1]), .ones(ones[1]), .carry_out(carry[1]),
`ifdef BCD_COUNTER_DOWN_EN
    .borrow_out(borrow[1]),
`endif
    .load_err(lerr[1]));

  bcd_pair_counter #(.MOD_VAL(100), .MIN_VAL(1), .DYN_TOP(1)) u_c (
    .clk(clk), .rst_n(rst_n), .inc(inc[2]), .load(load[2]),
    .load_bcd(lbcd[2]), .top_bcd(top_c),
`ifdef BCD_COUNTER_DOWN_EN
    .dec(dec[2]),
`endif
    .tens(tens[2]), .ones(ones[2]), .carry_out(carry[2]),
`ifdef BCD_COUNTER_DOWN_EN
    .borrow_out(borrow[2]),
`endif
    .load_err(lerr[2]));

  int errors = 0;
  int checks = 0;
  int mv[3];
  int ec[3], eb[3], ee[3];

  function automatic int minv(int i);
    return (i == 0) ? 0 : 1;
  endfunction

  function automatic int stopv(int i);
    return (i == 0) ? 59 : (i == 1) ? 12 : 99;
  endfunction

  function automatic bit bv(logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int b2i(logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2b(int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    int t;
    for (int i = 0; i < 3; i++) begin
      ec[i] = 0; eb[i] = 0; ee[i] = 0;
      if (!rst_n) begin
        mv[i] = minv(i);
      end else begin
        if (i == 2)
          t = (bv(top_c) && b2i(top_c) >= minv(i)) ? b2i(top_c) : minv(i);
        else
          t = stopv(i);
        if (load[i]) begin
          if (bv(lbcd[i]) && b2i(lbcd[i]) >= minv(i) && b2i(lbcd[i]) <= t)
            mv[i] = b2i(lbcd[i]);
          else
            ee[i] = 1;
        end else if (inc[i] && !(DOWN && dec[i])) begin
          if (mv[i] >= t) begin
            mv[i] = minv(i); ec[i] = 1;
          end else mv[i] = mv[i] + 1;
        end else if (DOWN && dec[i] && !inc[i]) begin
          if (mv[i] <= minv(i)) begin
            mv[i] = t; eb[i] = 1;
          end else mv[i] = mv[i] - 1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("val[%0d]", i), {tens[i], ones[i]}, i2b(mv[i]));
      chk($sformatf("carry[%0d]", i), carry[i], ec[i]);
      chk($sformatf("lerr[%0d]", i), lerr[i], ee[i]);
      if (DOWN) chk($sformatf("borrow[%0d]", i), borrow[i], eb[i]);
    end
  endtask

  task automatic idle();
    rst_n = 1'b1;
    inc = '0; dec = '0; load = '0;
    lbcd = '0;
  endtask

  typedef struct {
    bit         rst;
    bit         inc;
    bit         ld;
    logic [7:0] lb;
    logic [7:0] ev;
    bit         ec;
    bit         ee;
  } vec_t;

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'h47, 8'h47, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h6A, 8'h47, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 8'h60, 8'h47, 1'b0, 1'b1};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h23, 8'h23, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h24, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 8'h59, 8'h59, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 8'h37, 8'h37, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b1, 8'h45, 8'h00, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h99, 8'h10, 1'b0, 1'b1};

    idle();
    top_c = 8'h99;
    rst_n = 1'b0;
    step();
    step();
    chk("reset_a", {tens[0], ones[0]}, 8'h00);
    chk("reset_b", {tens[1], ones[1]}, 8'h01);
    chk("reset_c", {tens[2], ones[2]}, 8'h01);
    chk("reset_pulses", {carry, lerr}, 0);

    foreach (tbl[k]) begin
      idle();
      rst_n   = tbl[k].rst;
      inc[0]  = tbl[k].inc;
      load[0] = tbl[k].ld;
      lbcd[0] = tbl[k].lb;
      step();
      chk($sformatf("tbl%0d_val", k), {tens[0], ones[0]}, tbl[k].ev);
      chk($sformatf("tbl%0d_carry", k), carry[0], tbl[k].ec);
      chk($sformatf("tbl%0d_err", k), lerr[0], tbl[k].ee);
    end

    // Full lap of the seconds field.
    idle(); rst_n = 1'b0; step();
    idle(); inc[0] = 1'b1;
    repeat (59) step();
    chk("lap59_val", {tens[0], ones[0]}, 8'h59);
    chk("lap59_carry", carry[0], 0);
    step();
    chk("lap60_val", {tens[0], ones[0]}, 8'h00);
    chk("lap60_carry", carry[0], 1);
    inc[0] = 1'b0;
    step();
    chk("lap_carry_drop", carry[0], 0);

    // MIN 1 month-like field.
    idle(); load[1] = 1'b1; lbcd[1] = 8'h12; step();
    chk("m13_load", {tens[1], ones[1]}, 8'h12);
    idle(); inc[1] = 1'b1; step();
    chk("m13_wrap", {tens[1], ones[1]}, 8'h01);
    chk("m13_carry", carry[1], 1);
    idle(); load[1] = 1'b1; lbcd[1] = 8'h00; step();
    chk("m13_below_min", lerr[1], 1);
    chk("m13_hold", {tens[1], ones[1]}, 8'h01);

    // Runtime top shrinking below the current value.
    idle(); top_c = 8'h31; load[2] = 1'b1; lbcd[2] = 8'h30; step();
    chk("dyn_load", {tens[2], ones[2]}, 8'h30);
    idle(); top_c = 8'h28; inc[2] = 1'b1; step();
    chk("dyn_wrap", {tens[2], ones[2]}, 8'h01);
    chk("dyn_carry", carry[2], 1);
    idle(); top_c = 8'h2A; load[2] = 1'b1; lbcd[2] = 8'h05; step();
    chk("dyn_badtop_err", lerr[2], 1);
    idle(); inc[2] = 1'b1; step();
    chk("dyn_badtop_val", {tens[2], ones[2]}, 8'h01);
    chk("dyn_badtop_carry", carry[2], 1);
    top_c = 8'h99;

`ifdef BCD_COUNTER_DOWN_EN
    idle(); load[0] = 1'b1; lbcd[0] = 8'h00; step();
    idle(); dec[0] = 1'b1; step();
    chk("down_wrap", {tens[0], ones[0]}, 8'h59);
    chk("down_borrow", borrow[0], 1);
    inc[0] = 1'b1; step();
    chk("both_hold", {tens[0], ones[0]}, 8'h59);
    chk("both_pulses", {borrow[0], carry[0]}, 0);
    idle(); dec[0] = 1'b1; step();
    chk("down_step", {tens[0], ones[0]}, 8'h58);
`endif

    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(99) != 0);
      for (int i = 0; i < 3; i++) begin
        inc[i]  = 1'($urandom_range(1));
        dec[i]  = ($urandom_range(2) == 0);
        load[i] = ($urandom_range(9) == 0);
        lbcd[i] = ($urandom_range(3) == 0) ? 8'($urandom)
                                           : i2b($urandom_range(99));
      end
      if ($urandom_range(15) == 0)
        top_c = ($urandom_range(7) == 0) ? 8'($urandom)
                                         : i2b($urandom_range(99, 1));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
